// File: rtl/adc_multi_if.sv
// adc_multi_if: request/response bundle for the multi-channel ADC sequencer.
// master = host side (drives request/analog inputs), slave = converter side.
interface adc_multi_if #(
   parameter int NCH = 4,
   parameter int DW  = 12,
   parameter int CHW = 2
);
   logic [NCH*32-1:0] anadata;
   logic              start;
   logic [CHW-1:0]    chsel;
   logic              scan;
   logic              OE;
   logic              EOC;
   logic [DW-1:0]     adc_data;
   logic [CHW-1:0]    adc_ch;
   logic              busy;
   logic              ovr;

   modport master (
      output anadata, start, chsel, scan, OE,
      input  EOC, adc_data, adc_ch, busy, ovr
   );

   modport slave (
      input  anadata, start, chsel, scan, OE,
      output EOC, adc_data, adc_ch, busy, ovr
   );
endinterface

// File: rtl/adc_multi.sv
// adc_multi: multi-channel ADC conversion sequencer (IDLE/ARMED/CONV/DONE/READ).
// A start pulse arms, its falling level launches a CONV_CYCLES-long conversion;
// the MSB-aligned DW-bit slice of the selected 32-bit word is published on the
// OE read strobe. Scan mode walks upward from chsel to the last channel.
// Optional overrun flag: define ADC_OVR_EN to build it; otherwise ovr is tied 0.
module adc_multi #(
   parameter int NCH         = 4,
   parameter int DW          = 12,
   parameter int CONV_CYCLES = 300,
   parameter int CHW         = 2
) (
   input logic        clk,
   input logic        rstn,
   adc_multi_if.slave bus
);
   localparam int CW = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
   localparam logic [CHW-1:0] LAST_CH = CHW'(NCH - 1);
   localparam logic [CW-1:0]  CNT_MAX = CW'(CONV_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ARMED = 3'd1,
      S_CONV  = 3'd2,
      S_DONE  = 3'd3,
      S_READ  = 3'd4
   } state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [CHW-1:0] cur_ch_q, cur_ch_d;
   logic           scan_l_q, scan_l_d;
   logic [DW-1:0]  result_q, result_d;
   logic [DW-1:0]  adc_data_q, adc_data_d;
   logic [CHW-1:0] adc_ch_q, adc_ch_d;
   logic           eoc_q, eoc_d;
   logic [CHW-1:0] chsel_c;
   logic [31:0]    slice_lsb;

   // Out-of-range channel requests collapse onto the last real channel
   always_comb begin
      chsel_c = bus.chsel;
      if (32'(bus.chsel) >= 32'(NCH)) chsel_c = LAST_CH;
   end

   // LSB of the MSB-aligned result slice inside the current channel word
   assign slice_lsb = 32'(cur_ch_q) * 32'd32 + 32'(32 - DW);

   // Next-state and datapath updates; start outside IDLE is ignored
   always_comb begin
      state_d    = state_q;
      cnt_d      = '0;
      cur_ch_d   = cur_ch_q;
      scan_l_d   = scan_l_q;
      result_d   = result_q;
      adc_data_d = adc_data_q;
      adc_ch_d   = adc_ch_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d  = S_ARMED;
               cur_ch_d = chsel_c;
               scan_l_d = bus.scan;
            end
         end
         S_ARMED: begin
            if (!bus.start) state_d = S_CONV;
         end
         S_CONV: begin
            if (cnt_q == CNT_MAX) begin
               state_d  = S_DONE;
               result_d = bus.anadata[slice_lsb +: DW];
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            if (bus.OE) begin
               state_d    = S_READ;
               adc_data_d = result_q;
               adc_ch_d   = cur_ch_q;
            end
         end
         S_READ: begin
            if (!bus.OE) begin
               if (scan_l_q && cur_ch_q != LAST_CH) begin
                  state_d  = S_CONV;
                  cur_ch_d = cur_ch_q + 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      // EOC is registered from the next state so it drops exactly with CONV
      eoc_d = (state_d != S_CONV);
   end

   // State and datapath registers, asynchronously cleared
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         cur_ch_q   <= '0;
         scan_l_q   <= 1'b0;
         result_q   <= '0;
         adc_data_q <= '0;
         adc_ch_q   <= '0;
         eoc_q      <= 1'b1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         cur_ch_q   <= cur_ch_d;
         scan_l_q   <= scan_l_d;
         result_q   <= result_d;
         adc_data_q <= adc_data_d;
         adc_ch_q   <= adc_ch_d;
         eoc_q      <= eoc_d;
      end
   end

   assign bus.EOC      = eoc_q;
   assign bus.adc_data = adc_data_q;
   assign bus.adc_ch   = adc_ch_q;
   assign bus.busy     = (state_q != S_IDLE);

`ifdef ADC_OVR_EN
   logic ovr_q, ovr_d, unread_q, unread_d;

   // Overrun: start while busy converting/holding, or a scan result landing
   // on top of one that was never read; cleared by the next accepted start
   always_comb begin
      ovr_d    = ovr_q;
      unread_d = unread_q;
      if (state_q == S_IDLE && bus.start) ovr_d = 1'b0;
      if ((state_q == S_CONV || state_q == S_DONE) && bus.start) ovr_d = 1'b1;
      if (state_q == S_CONV && state_d == S_DONE) begin
         unread_d = 1'b1;
         if (scan_l_q && unread_q) ovr_d = 1'b1;
      end
      if (state_q == S_DONE && state_d == S_READ) unread_d = 1'b0;
   end

   // Overrun flag registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ovr_q    <= 1'b0;
         unread_q <= 1'b0;
      end else begin
         ovr_q    <= ovr_d;
         unread_q <= unread_d;
      end
   end

   assign bus.ovr = ovr_q;
`else
   assign bus.ovr = 1'b0;
`endif
endmodule

// File: tb/tb_adc_multi.sv
// tb_adc_multi: randomized transaction-level check of adc_multi against a
// reference model of expected reads (channel list, MSB-aligned values, EOC
// low time), plus reset-abort and channel-clamp cases.
module tb_adc_multi;
   localparam int NCH = 4, DW = 12, CC = 10, CHW = 2;
   localparam int SCC = 3;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   adc_multi_if #(.NCH(NCH), .DW(DW), .CHW(CHW)) m_if ();
   adc_multi #(.NCH(NCH), .DW(DW), .CONV_CYCLES(CC), .CHW(CHW)) dut (
      .clk(clk), .rstn(rstn), .bus(m_if.slave));

   adc_multi_if #(.NCH(2), .DW(DW), .CHW(2)) s_if ();
   adc_multi #(.NCH(2), .DW(DW), .CONV_CYCLES(SCC), .CHW(2)) dut_s (
      .clk(clk), .rstn(rstn), .bus(s_if.slave));

   int n_chk  = 0;
   int n_fail = 0;

   logic [31:0]    ana_w [NCH];
   logic [DW-1:0]  last_data;
   bit             ovr_exp;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] exp_of(input logic [31:0] w);
      return DW'(w >> (32 - DW));
   endfunction

   task automatic load_ana();
      for (int k = 0; k < NCH; k++) m_if.anadata[k*32 +: 32] = ana_w[k];
   endtask

   task automatic chk_ovr(input string tag);
`ifdef ADC_OVR_EN
      chk(tag, m_if.ovr, ovr_exp);
`else
      chk(tag, m_if.ovr, 0);
`endif
   endtask

   // One start-to-idle transaction; noise injects start/OE pulses during CONV
   task automatic run_txn(input int ch, input bit sc, input bit noise);
      int first, last;
      first = (ch >= NCH) ? NCH - 1 : ch;
      last  = sc ? NCH - 1 : first;
      @(negedge clk);
      m_if.start = 1'b1; m_if.chsel = CHW'(ch); m_if.scan = sc;
      ovr_exp = 1'b0;
      @(negedge clk);
      chk("armed_busy", m_if.busy, 1);
      chk("armed_eoc", m_if.EOC, 1);
      chk_ovr("ovr_clear_on_start");
      m_if.start = 1'b0;
      for (int k = first; k <= last; k++) begin
         int lo, cyc;
         bit done;
         lo = 0; cyc = 0; done = 1'b0;
         while (!done && cyc < CC * 4 + 20) begin
            @(negedge clk);
            cyc++;
            m_if.start = 1'b0;
            m_if.OE    = 1'b0;
            if (m_if.EOC == 1'b0) begin
               lo++;
               chk("conv_busy", m_if.busy, 1);
               if (noise && $urandom_range(0, 3) == 0) begin
                  m_if.start = 1'b1;
                  ovr_exp = 1'b1;
               end
               if (noise && $urandom_range(0, 3) == 0) m_if.OE = 1'b1;
            end else if (lo > 0) begin
               done = 1'b1;
            end
         end
         chk("eoc_rise_seen", done, 1);
         chk("eoc_low_cycles", lo, CC);
         chk("done_data_held", m_if.adc_data, last_data);
         chk_ovr("ovr_at_done");
         m_if.OE = 1'b1;
         @(negedge clk);
         chk("read_data", m_if.adc_data, exp_of(ana_w[k]));
         chk("read_ch", m_if.adc_ch, k);
         last_data = exp_of(ana_w[k]);
         m_if.OE = 1'b0;
      end
      @(negedge clk);
      chk("idle_busy", m_if.busy, 0);
      chk("idle_eoc", m_if.EOC, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      m_if.anadata = '0; m_if.start = 1'b0; m_if.chsel = '0; m_if.scan = 1'b0; m_if.OE = 1'b0;
      s_if.anadata = '0; s_if.start = 1'b0; s_if.chsel = '0; s_if.scan = 1'b0; s_if.OE = 1'b0;
      last_data = '0;
      ovr_exp = 1'b0;
      #12;
      chk("rst_eoc", m_if.EOC, 1);
      chk("rst_busy", m_if.busy, 0);
      chk("rst_data", m_if.adc_data, 0);
      chk("rst_ch", m_if.adc_ch, 0);
      chk("rst_ovr", m_if.ovr, 0);
      @(negedge clk);
      rstn = 1'b1;

      // Single channel, known value
      for (int k = 0; k < NCH; k++) ana_w[k] = $urandom;
      ana_w[2] = 32'hABC0_0000;
      load_ana();
      run_txn(2, 1'b0, 1'b0);

      // Scan from channel 1 with channel k holding k<<20
      for (int k = 0; k < NCH; k++) ana_w[k] = 32'(k) << 20;
      load_ana();
      run_txn(1, 1'b1, 1'b0);

      // Randomized transactions with start/OE noise during conversion
      repeat (8) begin
         for (int k = 0; k < NCH; k++) ana_w[k] = $urandom;
         load_ana();
         run_txn($urandom_range(0, NCH - 1), 1'($urandom_range(0, 1)), 1'b1);
      end

      // Reset during conversion at counter value 5
      begin
         int lo, cyc;
         bit saw_low;
         @(negedge clk);
         m_if.start = 1'b1; m_if.chsel = 2'd0; m_if.scan = 1'b0;
         @(negedge clk);
         m_if.start = 1'b0;
         lo = 0; cyc = 0;
         while (lo < 6 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (m_if.EOC == 1'b0) lo++;
         end
         chk("rst_mid_reached", lo, 6);
         #1 rstn = 1'b0;
         #1;
         chk("abort_eoc", m_if.EOC, 1);
         chk("abort_busy", m_if.busy, 0);
         chk("abort_data", m_if.adc_data, 0);
         chk("abort_ch", m_if.adc_ch, 0);
         chk("abort_ovr", m_if.ovr, 0);
         @(negedge clk);
         rstn = 1'b1;
         last_data = '0;
         saw_low = 1'b0;
         repeat (CC * 3) begin
            @(negedge clk);
            if (m_if.EOC == 1'b0 || m_if.busy == 1'b1) saw_low = 1'b1;
         end
         chk("no_conv_after_abort", saw_low, 0);
      end

      // Run one more transaction after the abort to confirm recovery
      for (int k = 0; k < NCH; k++) ana_w[k] = $urandom;
      load_ana();
      run_txn(NCH - 1, 1'b1, 1'b0);

      // Clamp on the NCH=2 instance: chsel=3 -> channel 1, OE held high
      begin
         int lo, cyc;
         bit done, data_moved;
         logic [31:0] s_w1;
         s_w1 = $urandom;
         s_if.anadata = {s_w1, 32'($urandom)};
         s_if.OE = 1'b1;
         @(negedge clk);
         s_if.start = 1'b1; s_if.chsel = 2'd3; s_if.scan = 1'b0;
         @(negedge clk);
         s_if.start = 1'b0;
         lo = 0; cyc = 0; done = 1'b0; data_moved = 1'b0;
         while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (s_if.adc_data !== '0) data_moved = 1'b1;
            if (s_if.EOC == 1'b0) lo++;
            else if (lo > 0) done = 1'b1;
         end
         chk("clamp_eoc_rise", done, 1);
         chk("clamp_low_cycles", lo, SCC);
         chk("clamp_data_held", data_moved, 0);
         @(negedge clk);
         chk("clamp_read_data", s_if.adc_data, exp_of(s_w1));
         chk("clamp_read_ch", s_if.adc_ch, 1);
         s_if.OE = 1'b0;
         @(negedge clk);
         chk("clamp_idle_busy", s_if.busy, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
